// File: rtl/adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq
// Function : Slices a WORDSIZE add/subtract into DATASIZE passes through an
//            external ripple adder and latches the result with 8085 flags.
// Revision : 1.0  initial release
// ============================================================================
module adder_seq #(
  parameter int DATASIZE = 8,
  parameter int WORDSIZE = 16
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic                iSub,
  input  logic                iUseC,
  input  logic                iCin,
  input  logic [WORDSIZE-1:0] iOpA,
  input  logic [WORDSIZE-1:0] iOpB,
  output logic [DATASIZE-1:0] oAddA,
  output logic [DATASIZE-1:0] oAddB,
  output logic [DATASIZE-1:0] oAddC,
  input  logic [DATASIZE-1:0] iAddS,
  input  logic [DATASIZE-1:0] iAddC,
  output logic [WORDSIZE-1:0] oResult,
  output logic                oCY,
  output logic                oZ,
  output logic                oS,
  output logic                oAC,
  output logic                oP,
  output logic                oBusy,
  output logic                oDone
);

  localparam int c_PASSES = WORDSIZE / DATASIZE;
  localparam int c_IDX_W  = (c_PASSES > 1) ? $clog2(c_PASSES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_PASSES - 1);
  localparam int c_AC_BIT = (DATASIZE > 3) ? 3 : DATASIZE - 1;
  localparam int c_PBITS  = (WORDSIZE < 8) ? WORDSIZE : 8;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_carry;
  logic                r_c3;
  logic                r_sub;
  logic [WORDSIZE-1:0] r_op_a;
  logic [WORDSIZE-1:0] r_op_b;
  logic [DATASIZE-1:0] r_acc_sl [c_PASSES];
  logic [DATASIZE-1:0] w_a_sl   [c_PASSES];
  logic [DATASIZE-1:0] w_b_sl   [c_PASSES];
  logic [WORDSIZE-1:0] w_new_result;
  logic                w_last;
  logic                w_c3;

  logic [WORDSIZE-1:0] r_result;
  logic                r_cy;
  logic                r_z;
  logic                r_s;
  logic                r_ac;
  logic                r_p;

  // Only the slice MSB carry and the bit-3 half carry matter here.
  logic w_unused_addc;
  assign w_unused_addc = ^iAddC;

  assign w_last = (r_idx == c_LAST);
  assign w_c3   = (r_idx == '0) ? iAddC[c_AC_BIT] : r_c3;

  for (genvar g = 0; g < c_PASSES; g++) begin : g_slice
    assign w_a_sl[g] = r_op_a[g*DATASIZE +: DATASIZE];
    assign w_b_sl[g] = r_op_b[g*DATASIZE +: DATASIZE];
    // The slice being computed this cycle comes straight from the adder.
    assign w_new_result[g*DATASIZE +: DATASIZE] =
      (r_idx == c_IDX_W'(g)) ? iAddS : r_acc_sl[g];

    always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
        r_acc_sl[g] <= '0;
      end else if (r_state == c_ST_RUN && r_idx == c_IDX_W'(g)) begin
        r_acc_sl[g] <= iAddS;
      end
    end
  end

  // State register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (iStart) w_state_next = c_ST_RUN;
      c_ST_RUN:  if (w_last) w_state_next = c_ST_DONE;
      c_ST_DONE: w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // Output logic: adder drive is quiet outside RUN
  always_comb begin
    oAddA = '0;
    oAddB = '0;
    oAddC = '0;
    oBusy = 1'b0;
    oDone = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        oAddA = w_a_sl[r_idx];
        oAddB = w_b_sl[r_idx] ^ {DATASIZE{r_sub}};
        oAddC = {{(DATASIZE-1){1'b0}}, r_carry};
        oBusy = 1'b1;
      end
      c_ST_DONE: begin
        oBusy = 1'b1;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, carry chaining and result/flag latch
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_c3     <= 1'b0;
      r_sub    <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_cy     <= 1'b0;
      r_z      <= 1'b0;
      r_s      <= 1'b0;
      r_ac     <= 1'b0;
      r_p      <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (iStart) begin
            r_op_a  <= iOpA;
            r_op_b  <= iOpB;
            r_sub   <= iSub;
            r_idx   <= '0;
            // Subtract runs as A + ~B + 1, so "no borrow" is carry-in 1.
            r_carry <= iSub ^ (iUseC & iCin);
          end
        end
        c_ST_RUN: begin
          r_carry <= iAddC[DATASIZE-1];
          if (r_idx == '0) r_c3 <= iAddC[c_AC_BIT];
          if (w_last) begin
            r_idx    <= '0;
            r_result <= w_new_result;
            r_cy     <= iAddC[DATASIZE-1] ^ r_sub;
            r_ac     <= w_c3 ^ r_sub;
            r_z      <= (w_new_result == '0);
            r_s      <= w_new_result[WORDSIZE-1];
            r_p      <= ~^w_new_result[c_PBITS-1:0];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oResult = r_result;
  assign oCY     = r_cy;
  assign oZ      = r_z;
  assign oS      = r_s;
  assign oAC     = r_ac;
  assign oP      = r_p;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_seq
// Function : Directed self-checking bench for adder_seq with a ripple adder model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_seq;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iStart, iSub, iUseC, iCin;
  logic [15:0] iOpA, iOpB;
  logic [7:0]  oAddA, oAddB, oAddC;
  logic [7:0]  iAddS, iAddC;
  logic [15:0] oResult;
  logic        oCY, oZ, oS, oAC, oP, oBusy, oDone;

  int checks = 0;
  int errors = 0;
  logic [7:0] first_addb, first_addc;

  always #5 iClock = ~iClock;

  adder_seq #(.DATASIZE(8), .WORDSIZE(16)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iSub(iSub),
    .iUseC(iUseC), .iCin(iCin), .iOpA(iOpA), .iOpB(iOpB),
    .oAddA(oAddA), .oAddB(oAddB), .oAddC(oAddC),
    .iAddS(iAddS), .iAddC(iAddC),
    .oResult(oResult), .oCY(oCY), .oZ(oZ), .oS(oS), .oAC(oAC), .oP(oP),
    .oBusy(oBusy), .oDone(oDone)
  );

  // External ripple adder: per-bit carry out, carry-in on iC[0]
  function automatic logic [15:0] ripple(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin);
    logic       c;
    logic [7:0] s, co;
    c = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      co[i] = c;
    end
    return {co, s};
  endfunction

  assign {iAddC, iAddS} = ripple(oAddA, oAddB, oAddC[0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {oCY, oZ, oS, oAC, oP};
  endfunction

  // Starts one op from IDLE, waits for oDone, then lets DONE return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic usec, input logic cin);
    int   n;
    logic seen;
    @(negedge iClock);
    iOpA = a; iOpB = b; iSub = sub; iUseC = usec; iCin = cin; iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0; iOpA = 16'hDEAD; iOpB = 16'hBEEF; iSub = ~sub; iCin = ~cin;
    first_addb = oAddB;
    first_addc = oAddC;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge iClock); #1;
      n++;
      seen = oDone;
    end
    check({tag, "_latency"}, n, 2);
    @(posedge iClock); #1;
    check({tag, "_done_pulse"}, {oBusy, oDone}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iReset = 1'b0; iStart = 1'b0; iSub = 1'b0; iUseC = 1'b0; iCin = 1'b0;
    iOpA = '0; iOpB = '0;
    repeat (2) @(negedge iClock);
    check("reset_result", oResult, 16'h0000);
    check("reset_flags", flags(), 5'b00000);
    check("reset_ctrl", {oBusy, oDone}, 2'b00);
    check("reset_drive", {oAddA, oAddB, oAddC}, 24'h0);
    @(negedge iClock);
    iReset = 1'b1;

    run_op("add1", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
    check("add1_addb_pass0", {first_addb, first_addc}, 16'hCD00);
    check("add1_result", oResult, 16'h2201);
    check("add1_flags", flags(), 5'b00010);

    run_op("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("add2_result", oResult, 16'h0000);
    check("add2_flags", flags(), 5'b11011);

    run_op("sub1", 16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("sub1_addb_pass0", {first_addb, first_addc}, 16'hFE01);
    check("sub1_result", oResult, 16'h0FFF);
    check("sub1_flags", flags(), 5'b00011);

    run_op("sub2", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("sub2_result", oResult, 16'hFFFF);
    check("sub2_flags", flags(), 5'b10111);

    run_op("adc", 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("adc_result", oResult, 16'h0100);
    check("adc_flags", flags(), 5'b00011);

    // iStart held high across RUN and DONE
    @(negedge iClock);
    iOpA = 16'h0001; iOpB = 16'h0002; iSub = 1'b0; iUseC = 1'b0; iStart = 1'b1;
    @(posedge iClock); #1;
    check("hold_e0_busy", oBusy, 1'b1);
    iOpA = 16'h1111; iOpB = 16'h2222;
    @(posedge iClock); #1;
    check("hold_e1_result", {oDone, oResult}, {1'b0, 16'h0100});
    @(posedge iClock); #1;
    check("hold_e2_done", {oDone, oResult}, {1'b1, 16'h0003});
    check("hold_e2_flags", flags(), 5'b00001);
    @(posedge iClock); #1;
    check("hold_e3_idle", {oBusy, oDone}, 2'b00);
    @(posedge iClock); #1;
    check("hold_e4_run", {oBusy, oResult}, {1'b1, 16'h0003});
    @(posedge iClock); #1;
    @(posedge iClock); #1;
    check("hold_e6_done", {oDone, oResult}, {1'b1, 16'h3333});
    check("hold_e6_flags", flags(), 5'b00001);
    iStart = 1'b0;
    @(posedge iClock); #1;
    check("hold_e7_idle", oBusy, 1'b0);

    // Asynchronous reset during RUN
    @(negedge iClock);
    iOpA = 16'hAAAA; iOpB = 16'h5555; iSub = 1'b0; iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    @(negedge iClock);
    check("rst_run_drive", oAddA, 8'hAA);
    iReset = 1'b0;
    #1;
    check("rst_ctrl", {oBusy, oDone}, 2'b00);
    check("rst_result", oResult, 16'h0000);
    check("rst_flags", flags(), 5'b00000);
    check("rst_drive", {oAddA, oAddB, oAddC}, 24'h0);
    @(negedge iClock);
    iReset = 1'b1;
    begin
      logic any_active;
      any_active = 1'b0;
      repeat (4) begin
        @(posedge iClock); #1;
        any_active = any_active | oDone | oBusy;
      end
      check("rst_no_done", any_active, 1'b0);
    end

    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("post_rst_result", oResult, 16'h0100);
    check("post_rst_flags", flags(), 5'b00011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Multi-pass sequencer that sits directly in front of the shared DATASIZE-bit ripple adder.
- Slices a WORDSIZE-bit add or subtract (e.g. 8085 DAD, 16-bit inc/dec) into DATASIZE-bit passes. Drives the adder operand and carry inputs, then consumes the adder's sum and carry outputs.
- Chains the carry between passes and latches the full result plus 8085-style flags for the register file and flag register.

Parameters:
DATASIZE, 8, width of the attached adder slice
WORDSIZE, 16, operand width; must be an integer multiple of DATASIZE (PASSES = WORDSIZE/DATASIZE, at least 1)

Ports:
iClock  input  1  system clock, rising edge
iReset  input  1  asynchronous reset, active-low
iStart  input  1  request; accepted only in IDLE
iSub  input  1  1 = A - B - borrow, 0 = A + B + carry
iUseC  input  1  1 = include iCin as carry/borrow in
iCin  input  1  incoming CY flag
iOpA  input  WORDSIZE  operand A
iOpB  input  WORDSIZE  operand B
oAddA  output  DATASIZE  to adder iA
oAddB  output  DATASIZE  to adder iB
oAddC  output  DATASIZE  to adder iC; bit0 = slice carry-in, other bits 0 (ripple mode)
iAddS  input  DATASIZE  from adder oS
iAddC  input  DATASIZE  from adder oC
oResult  output  WORDSIZE  latched result
oCY  output  1  carry (add) / borrow (sub)
oZ  output  1  oResult == 0
oS  output  1  oResult[WORDSIZE-1]
oAC  output  1  auxiliary carry from slice 0
oP  output  1  even parity of oResult[7:0]
oBusy  output  1  high in RUN and DONE
oDone  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, iReset=0):
  - State IDLE, slice index 0, internal carry 0.
  - oResult, all flags, oBusy, oDone = 0.
  - oAddA/oAddB/oAddC = 0.
  - Reset during RUN or DONE aborts the operation; no oDone is issued.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - Adder drive outputs are 0.
  - On an edge with iStart=1: capture iOpA and iOpB, go to RUN with index=0.
  - Initial carry: add = iUseC & iCin; sub = ~(iUseC & iCin).
- RUN, combinational adder drive:
  - oAddA = A slice[index].
  - oAddB = B slice[index], bitwise inverted when iSub=1 (iSub captured at start).
  - oAddC[0] = chained carry.
- RUN, each edge:
  - Write iAddS into result slice[index].
  - Carry <= iAddC[DATASIZE-1].
  - On index 0, capture c3 = iAddC[3].
  - Increment index.
  - After slice PASSES-1 is written, go to DONE.
- oResult and all flags update together on the edge entering DONE. Before that they hold the previous operation's values.
- Flag values:
  - oCY = final carry, inverted when iSub=1.
  - oAC = c3, inverted when iSub=1.
  - oZ, oS, oP computed from the new result.
- DONE: oDone=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge E0; oDone high during the cycle following edge E(PASSES). Default config: oDone two cycles after E0.
- iStart during RUN or DONE is ignored. Start is accepted again from IDLE; back-to-back throughput is one op per PASSES+2 cycles.
- Operand and control inputs are don't-care after capture.
- Outputs hold until the next op completes.
- WORDSIZE == DATASIZE: single pass, same protocol.

Test Plan:
- Add 0x1234 + 0x0FCD, iUseC=0 -> oResult=0x2201, CY=0, AC=1, Z=0, S=0, P=0; oDone exactly 2 cycles after the start edge.
- Add 0xFFFF + 0x0001 -> oResult=0x0000, CY=1, Z=1, AC=1, P=1, S=0.
- Sub 0x1000 - 0x0001, iUseC=0 -> oResult=0x0FFF, CY=0, AC=1, P=1, S=0; oAddB=0xFE during the first pass.
- Sub 0x0000 - 0x0001 -> oResult=0xFFFF, CY=1, S=1, Z=0; then add 0x00FF + 0x0000 with iUseC=1, iCin=1 -> oResult=0x0100, CY=0.
- iStart held high through RUN and DONE -> only one op per IDLE visit; second op begins from IDLE with new operands; oResult holds the previous value until its DONE.
- Assert iReset=0 mid-RUN -> oBusy, oDone, oResult, flags and adder drive all 0 immediately. After release, a fresh op completes normally.
